// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: packet codes, scheduler FSM states and a
// small elaboration-time helper.
package usb_pkg;

  typedef enum logic [1:0] {
    PKT_DATA0 = 2'd0,
    PKT_ACK   = 2'd1,
    PKT_NAK   = 2'd2,
    PKT_STALL = 2'd3
  } pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_ACT = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Free-running up counter with synchronous clear; the owner decides when the
// count is meaningful and when it expires.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tx_packet_scheduler.sv
// Arbitrates handshake and DATA0 requests onto the TX serializer, supervises
// the start timeout and enforces the inter-packet gap.
module tx_packet_scheduler
  import usb_pkg::*;
#(
  parameter int START_TIMEOUT = 8,
  parameter int IPG_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic [6:0] Buffer_Occupancy,
  input  logic       TX_Transfer_Active,
  input  logic       TX_Error,
  output logic       TX_Start,
  output logic [1:0] TX_Packet,
  output logic       hs_done,
  output logic       data_done,
  output logic       data_naked,
  output logic       tx_fault,
  output logic       busy,
  output logic [2:0] fsm_state
);

  localparam int CNT_W = $clog2(max_int(START_TIMEOUT, IPG_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IPG_LAST     = CNT_W'(IPG_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             hs_pend;
  logic             data_pend;
  logic [1:0]       hs_type_q;
  pkt_t             pkt_q;
  logic             is_data;
  logic             naked;
  logic             err_seen;
  logic             grant_hs;
  logic             grant_data;
  logic             cnt_clear;
  logic             cnt_en;
  logic [CNT_W-1:0] count;

  // IDLE always moves to START when anything is pending, so a grant is
  // exactly the IDLE->START transition.
  assign grant_hs   = (state == ST_IDLE) && hs_pend;
  assign grant_data = (state == ST_IDLE) && !hs_pend && data_pend;

  assign cnt_clear = (next_state != state);
  assign cnt_en    = (state == ST_WAIT_ACT) || (state == ST_GAP);

  flex_counter #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (cnt_clear),
    .count_enable(cnt_en),
    .count       (count)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (hs_pend || data_pend) next_state = ST_START;
      end
      ST_START: next_state = ST_WAIT_ACT;
      ST_WAIT_ACT: begin
        // A late TX_Transfer_Active in the final timeout cycle still wins.
        if (TX_Transfer_Active)          next_state = ST_ACTIVE;
        else if (count == TIMEOUT_LAST)  next_state = ST_GAP;
      end
      ST_ACTIVE: begin
        if (!TX_Transfer_Active) next_state = ST_GAP;
      end
      ST_GAP: begin
        if (count == IPG_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    TX_Start   = 1'b0;
    hs_done    = 1'b0;
    data_done  = 1'b0;
    data_naked = 1'b0;
    tx_fault   = 1'b0;
    case (state)
      ST_START: TX_Start = 1'b1;
      ST_WAIT_ACT: begin
        tx_fault = !TX_Transfer_Active && (count == TIMEOUT_LAST);
      end
      ST_ACTIVE: begin
        tx_fault = TX_Error && !err_seen;
        if (!TX_Transfer_Active) begin
          hs_done    = !is_data;
          data_done  = is_data;
          data_naked = is_data && naked;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;
  assign TX_Packet = pkt_q;

  // A pulse in the grant cycle re-arms its flag because the OR term wins.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hs_pend   <= 1'b0;
      data_pend <= 1'b0;
      hs_type_q <= 2'd0;
      pkt_q     <= PKT_DATA0;
      is_data   <= 1'b0;
      naked     <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      hs_pend   <= hs_req   | (hs_pend   & ~grant_hs);
      data_pend <= data_req | (data_pend & ~grant_data);
      if (hs_req) hs_type_q <= hs_type;

      if (grant_hs) begin
        pkt_q   <= pkt_t'(hs_type_q);
        is_data <= 1'b0;
        naked   <= 1'b0;
      end else if (grant_data) begin
        is_data <= 1'b1;
        if (Buffer_Occupancy == 7'd0) begin
          pkt_q <= PKT_NAK;
          naked <= 1'b1;
        end else begin
          pkt_q <= PKT_DATA0;
          naked <= 1'b0;
        end
      end

      // One fault pulse per packet even if TX_Error stays high.
      if (state == ST_START) begin
        err_seen <= 1'b0;
      end else if (state == ST_ACTIVE && TX_Error) begin
        err_seen <= 1'b1;
      end
    end
  end

endmodule
